simd_pipe_reg: RTL and testbench

- Parametrised successor of the single 16-bit clock-enabled pipeline register.
- Carries LANES x LANE_W SIMD data, with a valid bit and a per-lane active mask, through DEPTH stages.
- Adds global stall (ce_reg low), pipeline flush, masked-lane zeroing and an occupancy count.
- Sits between SIMD DLX pipeline stages (e.g. EX->MEM) wherever multi-cycle or multi-stage staging is needed.

---
 rtl/simd_pipe_reg.sv | 89 ++++++++
 tb/tb_simd_pipe_reg.sv | 137 +++++++++++++
 2 files changed

// File: rtl/simd_pipe_reg.sv
// DEPTH-stage SIMD pipeline register carrying valid, a per-lane mask and lane data,
// with global stall, flush, masked-lane zeroing and a registered occupancy count.
module simd_pipe_reg #(
    parameter int LANE_W = 16,
    parameter int LANES  = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ce_reg,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic [LANES-1:0]          lane_mask_in,
    input  logic [LANES*LANE_W-1:0]   data_in,
    output logic                      valid_out,
    output logic [LANES-1:0]          lane_mask_out,
    output logic [LANES*LANE_W-1:0]   data_out,
    output logic [CNT_W-1:0]          occupancy
);

    logic [DEPTH-1:0]        vld_q, vld_d;
    logic [LANES-1:0]        msk_q [DEPTH];
    logic [LANES-1:0]        msk_d [DEPTH];
    logic [LANES*LANE_W-1:0] dat_q [DEPTH];
    logic [LANES*LANE_W-1:0] dat_d [DEPTH];
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Inactive lanes are forced to zero so stale lane contents never travel downstream.
    function automatic logic [LANES*LANE_W-1:0] mask_lanes(
        input logic [LANES*LANE_W-1:0] d,
        input logic [LANES-1:0]        m
    );
        logic [LANES*LANE_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    always_comb begin
        vld_d = vld_q;
        msk_d = msk_q;
        dat_d = dat_q;
        cnt_d = cnt_q;
        if (flush) begin
            vld_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                msk_d[k] = '0;
                dat_d[k] = '0;
            end
            cnt_d = '0;
        end else if (ce_reg) begin
            // Stage 0 takes the input beat (or a clean bubble); the rest shift down by one.
            vld_d[0] = valid_in;
            msk_d[0] = valid_in ? lane_mask_in : '0;
            dat_d[0] = valid_in ? mask_lanes(data_in, lane_mask_in) : '0;
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                msk_d[k] = msk_q[k-1];
                dat_d[k] = dat_q[k-1];
            end
            cnt_d = cnt_q + CNT_W'(valid_in) - CNT_W'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                msk_q[k] <= '0;
                dat_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            msk_q <= msk_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_out     = vld_q[DEPTH-1];
    assign lane_mask_out = msk_q[DEPTH-1];
    assign data_out      = dat_q[DEPTH-1];
    assign occupancy     = cnt_q;

endmodule

// File: tb/tb_simd_pipe_reg.sv
// Directed bench for simd_pipe_reg (LANES=4, LANE_W=16, DEPTH=2): vector table plus
// hand-written flush and reset-mid-stream sequences.
module tb_simd_pipe_reg;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ce_reg = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [3:0]  lane_mask_in = '0;
    logic [63:0] data_in = '0;
    logic        valid_out;
    logic [3:0]  lane_mask_out;
    logic [63:0] data_out;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    simd_pipe_reg #(.LANE_W(16), .LANES(4), .DEPTH(2)) dut (
        .clock(clock), .reset(reset), .ce_reg(ce_reg), .flush(flush),
        .valid_in(valid_in), .lane_mask_in(lane_mask_in), .data_in(data_in),
        .valid_out(valid_out), .lane_mask_out(lane_mask_out), .data_out(data_out),
        .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst, ce, fl, vin;
        logic [3:0]  m;
        logic [63:0] d;
        logic        exp_v;
        logic [3:0]  exp_m;
        logic [63:0] exp_d;
        logic [1:0]  exp_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rst, input logic ce, input logic fl,
                       input logic vin, input logic [3:0] m, input logic [63:0] d,
                       input logic ev, input logic [3:0] em, input logic [63:0] ed,
                       input logic [1:0] eo);
        vec_t v;
        v.name = name; v.rst = rst; v.ce = ce; v.fl = fl; v.vin = vin; v.m = m; v.d = d;
        v.exp_v = ev; v.exp_m = em; v.exp_d = ed; v.exp_occ = eo;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic rst, input logic ce, input logic fl,
                         input logic vin, input logic [3:0] m, input logic [63:0] d);
        reset = rst; ce_reg = ce; flush = fl; valid_in = vin; lane_mask_in = m; data_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic [3:0] em,
                         input logic [63:0] ed, input logic [1:0] eo);
        checks++;
        if (valid_out !== ev || lane_mask_out !== em || data_out !== ed || occupancy !== eo) begin
            errors++;
            $display("FAIL %s: got v=%b m=%b d=%h occ=%0d, expected v=%b m=%b d=%h occ=%0d",
                     name, valid_out, lane_mask_out, data_out, occupancy, ev, em, ed, eo);
        end
    endtask

    initial begin
        // reset and idle
        add("rst_a",    1,1,0,0, 4'h0, 64'h0,                    0,4'h0,64'h0,0);
        add("rst_b",    1,0,0,1, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF,  0,4'h0,64'h0,0);
        add("idle_a",   0,1,0,0, 4'hF, 64'h1111_2222_3333_4444,  0,4'h0,64'h0,0);
        add("idle_b",   0,1,0,0, 4'h0, 64'h0,                    0,4'h0,64'h0,0);
        // streaming latency
        add("strm_a",   0,1,0,1, 4'hF, 64'h0004_0003_0002_0001,  0,4'h0,64'h0,1);
        add("strm_b",   0,1,0,1, 4'hF, 64'h0008_0007_0006_0005,  1,4'hF,64'h0004_0003_0002_0001,2);
        add("strm_c",   0,1,0,0, 4'h0, 64'h0,                    1,4'hF,64'h0008_0007_0006_0005,1);
        add("strm_d",   0,1,0,0, 4'h0, 64'h0,                    0,4'h0,64'h0,0);
        // lane masking, bubble with junk inputs, valid beat with empty mask
        add("mask_a",   0,1,0,1, 4'h5, 64'hAAAA_BBBB_CCCC_DDDD,  0,4'h0,64'h0,1);
        add("mask_b",   0,1,0,0, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF,  1,4'h5,64'h0000_BBBB_0000_DDDD,1);
        add("empty_a",  0,1,0,1, 4'h0, 64'h1111_2222_3333_4444,  0,4'h0,64'h0,1);
        add("empty_b",  0,1,0,0, 4'h0, 64'h0,                    1,4'h0,64'h0,1);
        add("empty_c",  0,1,0,0, 4'h0, 64'h0,                    0,4'h0,64'h0,0);
        // stall: load two beats, hold five cycles with new inputs, then drain
        add("load_a",   0,1,0,1, 4'hF, 64'h0101_0202_0303_0404,  0,4'h0,64'h0,1);
        add("load_b",   0,1,0,1, 4'hF, 64'h0505_0606_0707_0808,  1,4'hF,64'h0101_0202_0303_0404,2);
        for (int i = 0; i < 5; i++)
            add($sformatf("stall_%0d", i), 0,0,0,1, 4'hF, 64'hDEAD_BEEF_CAFE_0000 + 64'(i),
                1,4'hF,64'h0101_0202_0303_0404,2);
        add("drain_a",  0,1,0,0, 4'h0, 64'h0,                    1,4'hF,64'h0505_0606_0707_0808,1);
        add("drain_b",  0,1,0,0, 4'h0, 64'h0,                    0,4'h0,64'h0,0);
        add("drain_c",  0,1,0,0, 4'h0, 64'h0,                    0,4'h0,64'h0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].ce, vecs[i].fl, vecs[i].vin, vecs[i].m, vecs[i].d);
            check(vecs[i].name, vecs[i].exp_v, vecs[i].exp_m, vecs[i].exp_d, vecs[i].exp_occ);
        end

        // flush beats advance, and the beat offered alongside it is discarded
        apply(0,1,0,1, 4'hF, 64'h1111_1111_1111_1111);
        check("fl_load_a", 0, 4'h0, 64'h0, 1);
        apply(0,1,0,1, 4'hF, 64'h2222_2222_2222_2222);
        check("fl_load_b", 1, 4'hF, 64'h1111_1111_1111_1111, 2);
        apply(0,1,1,1, 4'hF, 64'h1234_1234_1234_1234);
        check("flush", 0, 4'h0, 64'h0, 0);
        apply(0,1,0,0, 4'h0, 64'h0);
        check("fl_after_a", 0, 4'h0, 64'h0, 0);
        apply(0,1,0,0, 4'h0, 64'h0);
        check("fl_after_b", 0, 4'h0, 64'h0, 0);
        // flush also clears while stalled
        apply(0,1,0,1, 4'h3, 64'h5555_6666_7777_8888);
        check("fl_stall_load", 0, 4'h0, 64'h0, 1);
        apply(0,0,1,0, 4'h0, 64'h0);
        check("fl_stall", 0, 4'h0, 64'h0, 0);
        apply(0,1,0,0, 4'h0, 64'h0);
        check("fl_stall_after", 0, 4'h0, 64'h0, 0);

        // reset mid-stream, then a fresh beat passes through intact
        apply(0,1,0,1, 4'hF, 64'hF1F1_F1F1_F1F1_F1F1);
        apply(0,1,0,1, 4'hF, 64'hF2F2_F2F2_F2F2_F2F2);
        check("rs_loaded", 1, 4'hF, 64'hF1F1_F1F1_F1F1_F1F1, 2);
        apply(1,1,0,1, 4'hF, 64'hBADB_ADBA_DBAD_BADB);
        check("rs_reset", 0, 4'h0, 64'h0, 0);
        apply(0,1,0,1, 4'hA, 64'h9999_8888_7777_6666);
        check("rs_new_a", 0, 4'h0, 64'h0, 1);
        apply(0,1,0,0, 4'h0, 64'h0);
        check("rs_new_b", 1, 4'hA, 64'h9999_0000_7777_0000, 1);
        apply(0,1,0,0, 4'h0, 64'h0);
        check("rs_new_c", 0, 4'h0, 64'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
